// File: rtl/perceptron_trainer.sv
// Online perceptron trainer for a 2-input step neuron: learns saturating signed
// weights/bias that reproduce a 4-entry truth table, or stops at an epoch limit.
module perceptron_trainer #(
  parameter int W          = 8,
  parameter int LR         = 1,
  parameter int MAX_EPOCHS = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [3:0]          target,
  output logic                busy,
  output logic                done,
  output logic                converged,
  output logic signed [W-1:0] w_a,
  output logic signed [W-1:0] w_b,
  output logic signed [W-1:0] bias,
  output logic [5:0]          epochs,
  output logic [1:0]          dbg_state
);

  // Handshake: start is a one-cycle request, accepted only in IDLE or DONE;
  // busy covers every EVAL/CHECK cycle, done is a level held until the next accept.
  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_CHECK, S_DONE} state_t;

  localparam logic signed [W+1:0] LR_S   = (W+2)'(LR);
  localparam logic signed [W+1:0] SAT_HI = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] SAT_LO = {3'b111, {(W-1){1'b0}}};
  localparam logic [5:0]          MAX_E  = 6'(MAX_EPOCHS);

  state_t              r_state;
  logic [3:0]          r_target;
  logic [1:0]          r_p;
  logic                r_err;
  logic                r_busy;
  logic                r_done;
  logic                r_conv;
  logic signed [W-1:0] r_w_a;
  logic signed [W-1:0] r_w_b;
  logic signed [W-1:0] r_bias;
  logic [5:0]          r_epochs;

  logic                w_in_a;
  logic                w_in_b;
  logic signed [W+1:0] w_act;
  logic                w_z;
  logic                w_t;
  logic                w_err_pos;
  logic                w_err_neg;
  logic signed [W+1:0] w_delta;
  logic signed [W-1:0] w_w_a_nxt;
  logic signed [W-1:0] w_w_b_nxt;
  logic signed [W-1:0] w_bias_nxt;

  function automatic logic signed [W-1:0] f_sat_add(input logic signed [W-1:0] v,
                                                    input logic signed [W+1:0] d);
    logic signed [W+1:0] s;
    s = {{2{v[W-1]}}, v} + d;
    if (s > SAT_HI)      f_sat_add = SAT_HI[W-1:0];
    else if (s < SAT_LO) f_sat_add = SAT_LO[W-1:0];
    else                 f_sat_add = s[W-1:0];
  endfunction

  // Two extra bits of headroom make the three-term sum overflow-free.
  always_comb begin
    w_in_a    = r_p[1];
    w_in_b    = r_p[0];
    w_act     = (w_in_a ? {{2{r_w_a[W-1]}}, r_w_a} : '0)
              + (w_in_b ? {{2{r_w_b[W-1]}}, r_w_b} : '0)
              + {{2{r_bias[W-1]}}, r_bias};
    w_z       = ~w_act[W+1];
    w_t       = r_target[r_p];
    w_err_pos = w_t & ~w_z;
    w_err_neg = ~w_t & w_z;
    w_delta   = w_err_pos ? LR_S : (w_err_neg ? -LR_S : '0);
    w_w_a_nxt  = w_in_a ? f_sat_add(r_w_a, w_delta) : r_w_a;
    w_w_b_nxt  = w_in_b ? f_sat_add(r_w_b, w_delta) : r_w_b;
    w_bias_nxt = f_sat_add(r_bias, w_delta);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_target <= '0;
      r_p      <= '0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_conv   <= 1'b0;
      r_w_a    <= '0;
      r_w_b    <= '0;
      r_bias   <= '0;
      r_epochs <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_target <= target;
            r_p      <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_conv   <= 1'b0;
            r_w_a    <= '0;
            r_w_b    <= '0;
            r_bias   <= '0;
            r_epochs <= '0;
            r_state  <= S_EVAL;
          end
        end
        S_EVAL: begin
          r_w_a  <= w_w_a_nxt;
          r_w_b  <= w_w_b_nxt;
          r_bias <= w_bias_nxt;
          if (w_err_pos || w_err_neg) r_err <= 1'b1;
          r_p <= r_p + 2'd1;
          if (r_p == 2'd3) r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_epochs <= r_epochs + 6'd1;
          if (!r_err) begin
            r_conv  <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else if ((r_epochs + 6'd1) == MAX_E) begin
            r_conv  <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_err   <= 1'b0;
            r_p     <= '0;
            r_state <= S_EVAL;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign converged = r_conv;
  assign w_a       = r_w_a;
  assign w_b       = r_w_b;
  assign bias      = r_bias;
  assign epochs    = r_epochs;
  assign dbg_state = r_state;

endmodule
